timestep_sequencer: RTL

// Sequences one GravSim integration timestep over all bodies using the shared 3-lane FP update unit
// (FPmult x3 -> FPadd x3, X/Y/Z lanes). Per body, issues a velocity update (v += a*DT),

---
 rtl/timestep_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/timestep_sequencer.sv
// Sequences one integration timestep: per body a velocity update then a position update
// through the shared 3-lane FP unit, writing each XYZ result triple back to the datafile.
module timestep_sequencer #(
    parameter int MAX_BODIES = 10,
    parameter int TIMEOUT    = 64,
    parameter int ADDR_W     = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [31:0]       num_bodies,
    output logic              busy,
    output logic              done,
    output logic              err_clamp,
    output logic              err_timeout,
    output logic              op_valid,
    output logic              op_sel,
    output logic [3:0]        op_body,
    input  logic              res_valid,
    input  logic [31:0]       res_x,
    input  logic [31:0]       res_y,
    input  logic [31:0]       res_z,
    output logic              we,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic [ADDR_W-1:0] addr3,
    output logic [31:0]       wdata1,
    output logic [31:0]       wdata2,
    output logic [31:0]       wdata3,
    output logic [2:0]        dbg_state
);

    // Handshakes: op_valid is a one-cycle launch pulse; the datapath answers with a one-cycle
    // res_valid no earlier than the cycle after op_valid; we is a one-cycle commit pulse.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_V = 3'd1,
        S_WAIT_V  = 3'd2,
        S_WRITE_V = 3'd3,
        S_ISSUE_P = 3'd4,
        S_WAIT_P  = 3'd5,
        S_WRITE_P = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam int         CNT_W = $clog2(TIMEOUT);
    localparam logic [3:0] N_MAX = 4'(MAX_BODIES);

    state_t              state_q;
    logic [3:0]          n_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                err_clamp_q;
    logic                err_timeout_q;
    logic                op_valid_q;
    logic                op_sel_q;
    logic [3:0]          op_body_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr1_q;
    logic [ADDR_W-1:0]   addr2_q;
    logic [ADDR_W-1:0]   addr3_q;
    logic [31:0]         wdata1_q;
    logic [31:0]         wdata2_q;
    logic [31:0]         wdata3_q;

    logic                clamp;
    logic [4:0]          body_next;
    logic [ADDR_W-1:0]   addr_x;
    logic [ADDR_W-1:0]   addr_y;
    logic [ADDR_W-1:0]   addr_z;

    assign clamp     = num_bodies > 32'(MAX_BODIES);
    assign body_next = {1'b0, op_body_q} + 5'd1;

    // Velocity block lives at 53/63/73, position block at 23/33/43, one word per body.
    assign addr_x = (op_sel_q ? ADDR_W'(23) : ADDR_W'(53)) + ADDR_W'(op_body_q);
    assign addr_y = (op_sel_q ? ADDR_W'(33) : ADDR_W'(63)) + ADDR_W'(op_body_q);
    assign addr_z = (op_sel_q ? ADDR_W'(43) : ADDR_W'(73)) + ADDR_W'(op_body_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            wait_cnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_clamp_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            op_valid_q    <= 1'b0;
            op_sel_q      <= 1'b0;
            op_body_q     <= '0;
            we_q          <= 1'b0;
            addr1_q       <= '0;
            addr2_q       <= '0;
            addr3_q       <= '0;
            wdata1_q      <= '0;
            wdata2_q      <= '0;
            wdata3_q      <= '0;
        end else begin
            op_valid_q <= 1'b0;
            we_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_clamp_q   <= clamp;
                        err_timeout_q <= 1'b0;
                        n_q           <= clamp ? N_MAX : num_bodies[3:0];
                        if (num_bodies == 32'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_ISSUE_V;
                            busy_q     <= 1'b1;
                            op_valid_q <= 1'b1;
                            op_sel_q   <= 1'b0;
                            op_body_q  <= '0;
                        end
                    end
                end
                S_ISSUE_V: begin
                    state_q    <= S_WAIT_V;
                    wait_cnt_q <= '0;
                end
                S_ISSUE_P: begin
                    state_q    <= S_WAIT_P;
                    wait_cnt_q <= '0;
                end
                S_WAIT_V, S_WAIT_P: begin
                    if (res_valid) begin
                        state_q  <= (state_q == S_WAIT_V) ? S_WRITE_V : S_WRITE_P;
                        we_q     <= 1'b1;
                        addr1_q  <= addr_x;
                        addr2_q  <= addr_y;
                        addr3_q  <= addr_z;
                        wdata1_q <= res_x;
                        wdata2_q <= res_y;
                        wdata3_q <= res_z;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q       <= S_DONE;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        err_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                // The velocity write has committed by now, so the position op sees it.
                S_WRITE_V: begin
                    state_q    <= S_ISSUE_P;
                    op_sel_q   <= 1'b1;
                    op_valid_q <= 1'b1;
                end
                S_WRITE_P: begin
                    if (body_next < {1'b0, n_q}) begin
                        state_q    <= S_ISSUE_V;
                        op_sel_q   <= 1'b0;
                        op_body_q  <= body_next[3:0];
                        op_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_clamp   = err_clamp_q;
    assign err_timeout = err_timeout_q;
    assign op_valid    = op_valid_q;
    assign op_sel      = op_sel_q;
    assign op_body     = op_body_q;
    assign we          = we_q;
    assign addr1       = addr1_q;
    assign addr2       = addr2_q;
    assign addr3       = addr3_q;
    assign wdata1      = wdata1_q;
    assign wdata2      = wdata2_q;
    assign wdata3      = wdata3_q;
    assign dbg_state   = state_q;

endmodule
